pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumer-side companion to the fabric PLL wrappers: drives the PLL reset, watches the PLL `locked` output, and produces a clean reset for the generated clock domain.
- Runs on the PLL reference clock (50 MHz), so it keeps running when the PLL output clock is absent.
- Sequences PLL reset, lock wait with timeout and retry, and a lock-stability window before releasing downstream reset.
- Handles lock loss, soft restart and a sticky fault; exports status for a CSR.

Parameters:
- RST_HOLD_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
- LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before the attempt fails (>=1)
- LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release (>=1)
- MAX_RETRIES, 3, failed lock attempts allowed before FAULT (>=1)
- CNT_W, 8, width of lock_loss_cnt

Ports:
- clk  in  1  PLL reference clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked output; asynchronous to clk
- soft_reset_req  in  1  single-cycle request to restart the sequence
- pll_rst  out  1  active-high reset to the PLL
- sys_rst_n  out  1  active-low reset for the PLL output domain; consumer resynchronizes it
- locked_stable  out  1  high in RUN only
- fault  out  1  sticky; high in FAULT only
- lock_loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN
- state_o  out  3  0=RESET_PLL, 1=WAIT_LOCK, 2=STABILIZE, 3=RUN, 4=FAULT

Behaviour:
- Reset values: state RESET_PLL, pll_rst=1, sys_rst_n=0, locked_stable=0, fault=0, lock_loss_cnt=0, retry counter 0, timers 0.
- All outputs are registered and update on the same edge as the state change.
- pll_locked passes through a 2-flop synchronizer, reset to 0; its output is locked_sync.

RESET_PLL:
- pll_rst=1.
- Hold counter runs 0..RST_HOLD_CYCLES-1, then WAIT_LOCK; pll_rst=0 on that edge.

WAIT_LOCK:
- Timer increments each cycle.
- locked_sync=1: go to STABILIZE, clear timer.
- Timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_sync=0: increment retry counter. If the new value is below MAX_RETRIES, go to RESET_PLL; otherwise go to FAULT.

STABILIZE:
- Stable counter starts at 0 on entry.
- Each cycle with locked_sync=1: if count equals LOCK_STABLE_CYCLES-1, go to RUN; otherwise increment.
- locked_sync=0: go back to WAIT_LOCK, clear timer. This does not count as a retry.

RUN:
- sys_rst_n=1, locked_stable=1, retry counter cleared.
- locked_sync=0: go to RESET_PLL. sys_rst_n=0 on that edge. lock_loss_cnt increments, saturating at all-ones.

FAULT:
- pll_rst=1, sys_rst_n=0, fault=1.
- Left only via soft_reset_req.

soft_reset_req:
- In any state: go to RESET_PLL, clear hold counter, retry counter and timers, fault=0.
- In RESET_PLL: restarts the hold.
- Leaves lock_loss_cnt unchanged.

Priority:
- soft_reset_req and lock loss in the same RUN cycle: lock loss is counted and the next state is RESET_PLL.
- soft_reset_req beats a WAIT_LOCK timeout in the same cycle; the retry is not counted.

Latency:
- sys_rst_n rises exactly 3+LOCK_STABLE_CYCLES edges after pll_locked rises, provided WAIT_LOCK is active and lock holds.
- sys_rst_n falls 3 edges after pll_locked falls in RUN.

Asynchronous rst_n assertion in any state forces reset values immediately; the synchronizer is cleared too.

Test Plan:
Common bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2.
1. Release rst_n with pll_locked=0 -> pll_rst=1 for 4 cycles, then 0. Raise pll_locked in WAIT_LOCK -> sys_rst_n=1 and locked_stable=1 exactly 11 edges later; state_o=3.
2. In STABILIZE, drop pll_locked for 1 cycle at stable count 5 -> state_o=1, sys_rst_n stays 0, no retry counted. Restore lock -> release 11 edges after the re-rise.
3. Hold pll_locked=0 -> timeout after 20 cycles, pll_rst=1 for 4 cycles. Second timeout -> state_o=4, fault=1, pll_rst=1. Pulse soft_reset_req -> fault=0, state_o=0.
4. In RUN, drop pll_locked -> sys_rst_n=0 and state_o=0 3 edges later, lock_loss_cnt=1. Re-lock -> normal release.
5. Force 5 lock losses from RUN -> lock_loss_cnt saturates at 3. A soft_reset_req pulse leaves it at 3.
6. Assert rst_n mid-STABILIZE -> all outputs take reset values with no clock edge. Pulse soft_reset_req together with lock loss in RUN -> lock_loss_cnt increments and the next state is RESET_PLL.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer on the reference clock: holds the PLL in reset, waits for lock with timeout/retry,
// requires a stable-lock window, then releases the output-domain reset; tracks lock losses and a sticky fault.
module pll_lock_supervisor #(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             soft_reset_req,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             locked_stable,
   output logic             fault,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [2:0]       state_o
);

   localparam int HOLD_W   = $clog2(RST_HOLD_CYCLES + 1);
   localparam int TIMER_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t              state_q;
   logic                syncMeta_q;
   logic                lockedSync_q;
   logic [HOLD_W-1:0]   holdCnt_q;
   logic [TIMER_W-1:0]  waitTimer_q;
   logic [STABLE_W-1:0] stableCnt_q;
   logic [RETRY_W-1:0]  retryCnt_q;
   logic                pllRst_q;
   logic                sysRstN_q;
   logic                lockedStable_q;
   logic                fault_q;
   logic [CNT_W-1:0]    lockLossCnt_q;

   // pll_locked comes from the PLL's own timing domain, so it is resynchronized before use
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncMeta_q   <= 1'b0;
         lockedSync_q <= 1'b0;
      end else begin
         syncMeta_q   <= pll_locked;
         lockedSync_q <= syncMeta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RESET_PLL;
         holdCnt_q      <= '0;
         waitTimer_q    <= '0;
         stableCnt_q    <= '0;
         retryCnt_q     <= '0;
         pllRst_q       <= 1'b1;
         sysRstN_q      <= 1'b0;
         lockedStable_q <= 1'b0;
         fault_q        <= 1'b0;
         lockLossCnt_q  <= '0;
      end else if (state_q == RUN && !lockedSync_q) begin
         // Lock loss outranks a simultaneous soft reset so the loss is always counted
         state_q        <= RESET_PLL;
         holdCnt_q      <= '0;
         waitTimer_q    <= '0;
         stableCnt_q    <= '0;
         pllRst_q       <= 1'b1;
         sysRstN_q      <= 1'b0;
         lockedStable_q <= 1'b0;
         if (lockLossCnt_q != '1) begin
            lockLossCnt_q <= lockLossCnt_q + 1'b1;
         end
      end else if (soft_reset_req) begin
         state_q        <= RESET_PLL;
         holdCnt_q      <= '0;
         waitTimer_q    <= '0;
         stableCnt_q    <= '0;
         retryCnt_q     <= '0;
         pllRst_q       <= 1'b1;
         sysRstN_q      <= 1'b0;
         lockedStable_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (holdCnt_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                  state_q     <= WAIT_LOCK;
                  holdCnt_q   <= '0;
                  waitTimer_q <= '0;
                  pllRst_q    <= 1'b0;
               end else begin
                  holdCnt_q <= holdCnt_q + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lockedSync_q) begin
                  state_q     <= STABILIZE;
                  waitTimer_q <= '0;
                  stableCnt_q <= '0;
               end else if (waitTimer_q == TIMER_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  // The incremented retry count reaching MAX_RETRIES means the budget is spent
                  waitTimer_q <= '0;
                  retryCnt_q  <= retryCnt_q + 1'b1;
                  pllRst_q    <= 1'b1;
                  holdCnt_q   <= '0;
                  if (retryCnt_q >= RETRY_W'(MAX_RETRIES - 1)) begin
                     state_q <= FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= RESET_PLL;
                  end
               end else begin
                  waitTimer_q <= waitTimer_q + 1'b1;
               end
            end
            STABILIZE: begin
               if (!lockedSync_q) begin
                  state_q     <= WAIT_LOCK;
                  waitTimer_q <= '0;
                  stableCnt_q <= '0;
               end else if (stableCnt_q == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
                  state_q        <= RUN;
                  stableCnt_q    <= '0;
                  retryCnt_q     <= '0;
                  sysRstN_q      <= 1'b1;
                  lockedStable_q <= 1'b1;
               end else begin
                  stableCnt_q <= stableCnt_q + 1'b1;
               end
            end
            RUN: begin
               retryCnt_q <= '0;
            end
            FAULT: begin
               pllRst_q  <= 1'b1;
               sysRstN_q <= 1'b0;
               fault_q   <= 1'b1;
            end
            default: begin
               state_q  <= RESET_PLL;
               pllRst_q <= 1'b1;
            end
         endcase
      end
   end

   assign pll_rst       = pllRst_q;
   assign sys_rst_n     = sysRstN_q;
   assign locked_stable = lockedStable_q;
   assign fault         = fault_q;
   assign lock_loss_cnt = lockLossCnt_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters; expected values are hand-derived edge counts.
module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       locked_stable;
   logic       fault;
   logic [1:0] lock_loss_cnt;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;

   pll_lock_supervisor #(
      .RST_HOLD_CYCLES(4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES(8),
      .MAX_RETRIES(2),
      .CNT_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pll_locked(pll_locked),
      .soft_reset_req(soft_reset_req),
      .pll_rst(pll_rst),
      .sys_rst_n(sys_rst_n),
      .locked_stable(locked_stable),
      .fault(fault),
      .lock_loss_cnt(lock_loss_cnt),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
      #12;
      total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state_o); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_pll_rst got=%b exp=1", pll_rst); end
      total++; if (sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL reset_sys_rst_n got=%b exp=0", sys_rst_n); end
      total++; if (locked_stable !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked_stable got=%b exp=0", locked_stable); end
      total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
      total++; if (lock_loss_cnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", lock_loss_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_startup();
      tick(3);
      total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL startup_hold got=%b exp=1", pll_rst); end
      tick(1);
      total++; if (pll_rst !== 1'b0) begin bad++; $display("[TB] FAIL startup_pll_rst_fall got=%b exp=0", pll_rst); end
      total++; if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL startup_wait got=%0d exp=1", state_o); end
      pll_locked = 1'b1;
      tick(10);
      total++; if (sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL startup_early_release got=%b exp=0", sys_rst_n); end
      total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL startup_stabilize got=%0d exp=2", state_o); end
      tick(1);
      total++; if (sys_rst_n !== 1'b1) begin bad++; $display("[TB] FAIL startup_release got=%b exp=1", sys_rst_n); end
      total++; if (locked_stable !== 1'b1) begin bad++; $display("[TB] FAIL startup_locked_stable got=%b exp=1", locked_stable); end
      total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL startup_run got=%0d exp=3", state_o); end
   endtask

   task automatic test_lock_loss();
      pll_locked = 1'b0;
      tick(2);
      total++; if (sys_rst_n !== 1'b1) begin bad++; $display("[TB] FAIL loss_early got=%b exp=1", sys_rst_n); end
      tick(1);
      total++; if (sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL loss_sys_rst_n got=%b exp=0", sys_rst_n); end
      total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL loss_state got=%0d exp=0", state_o); end
      total++; if (lock_loss_cnt !== 2'd1) begin bad++; $display("[TB] FAIL loss_cnt got=%0d exp=1", lock_loss_cnt); end
      total++; if (locked_stable !== 1'b0) begin bad++; $display("[TB] FAIL loss_locked_stable got=%b exp=0", locked_stable); end
      tick(4);
      total++; if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL loss_rewait got=%0d exp=1", state_o); end
      pll_locked = 1'b1;
      tick(11);
      total++; if (state_o !== 3'd3 || sys_rst_n !== 1'b1) begin bad++; $display("[TB] FAIL loss_relock got=%0d/%b exp=3/1", state_o, sys_rst_n); end
   endtask

   task automatic test_stabilize_glitch();
      pll_locked = 1'b0; soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      total++; if (state_o !== 3'd0 || lock_loss_cnt !== 2'd1) begin bad++; $display("[TB] FAIL soft_in_run got=%0d/%0d exp=0/1", state_o, lock_loss_cnt); end
      tick(4);
      total++; if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL glitch_wait got=%0d exp=1", state_o); end
      pll_locked = 1'b1;
      tick(6);
      total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL glitch_stab got=%0d exp=2", state_o); end
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      total++; if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL glitch_back_to_wait got=%0d exp=1", state_o); end
      total++; if (sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL glitch_sys_rst_n got=%b exp=0", sys_rst_n); end
      tick(8);
      total++; if (state_o !== 3'd2 || sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL glitch_early got=%0d/%b exp=2/0", state_o, sys_rst_n); end
      tick(1);
      total++; if (state_o !== 3'd3 || sys_rst_n !== 1'b1) begin bad++; $display("[TB] FAIL glitch_release got=%0d/%b exp=3/1", state_o, sys_rst_n); end
   endtask

   task automatic test_timeout();
      pll_locked = 1'b0;
      tick(3);
      total++; if (state_o !== 3'd0 || lock_loss_cnt !== 2'd2) begin bad++; $display("[TB] FAIL to_loss got=%0d/%0d exp=0/2", state_o, lock_loss_cnt); end
      tick(4);
      tick(19);
      total++; if (state_o !== 3'd1 || pll_rst !== 1'b0) begin bad++; $display("[TB] FAIL to_before got=%0d/%b exp=1/0", state_o, pll_rst); end
      tick(1);
      total++; if (state_o !== 3'd0 || pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL to_first got=%0d/%b exp=0/1", state_o, pll_rst); end
      tick(3);
      total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL to_rehold got=%b exp=1", pll_rst); end
      tick(1);
      total++; if (state_o !== 3'd1 || pll_rst !== 1'b0) begin bad++; $display("[TB] FAIL to_rewait got=%0d/%b exp=1/0", state_o, pll_rst); end
      tick(20);
      total++; if (state_o !== 3'd4) begin bad++; $display("[TB] FAIL to_fault_state got=%0d exp=4", state_o); end
      total++; if (fault !== 1'b1 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL to_fault_outs got=%b%b%b exp=110", fault, pll_rst, sys_rst_n); end
      tick(5);
      total++; if (state_o !== 3'd4 || fault !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky got=%0d/%b exp=4/1", state_o, fault); end
      soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      total++; if (state_o !== 3'd0 || fault !== 1'b0 || pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL to_exit got=%0d/%b/%b exp=0/0/1", state_o, fault, pll_rst); end
   endtask

   task automatic test_soft_vs_timeout();
      tick(4);
      tick(19);
      soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL svt_state got=%0d exp=0", state_o); end
      tick(4);
      tick(20);
      total++; if (state_o !== 3'd0 || fault !== 1'b0) begin bad++; $display("[TB] FAIL svt_no_retry got=%0d/%b exp=0/0", state_o, fault); end
      tick(4);
      pll_locked = 1'b1;
      tick(11);
      total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL svt_run got=%0d exp=3", state_o); end
   endtask

   task automatic test_saturation();
      logic [1:0] expCnt;
      expCnt = 2'd2;
      for (int i = 0; i < 3; i++) begin
         pll_locked = 1'b0;
         tick(3);
         if (expCnt != 2'd3) expCnt = expCnt + 2'd1;
         total++; if (lock_loss_cnt !== expCnt) begin bad++; $display("[TB] FAIL sat_cnt%0d got=%0d exp=%0d", i, lock_loss_cnt, expCnt); end
         tick(4);
         pll_locked = 1'b1;
         tick(11);
         total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL sat_run%0d got=%0d exp=3", i, state_o); end
      end
      soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      total++; if (lock_loss_cnt !== 2'd3 || state_o !== 3'd0) begin bad++; $display("[TB] FAIL sat_soft got=%0d/%0d exp=3/0", lock_loss_cnt, state_o); end
      tick(13);
      total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL sat_relock got=%0d exp=3", state_o); end
   endtask

   task automatic test_async_reset();
      soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      tick(5);
      total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL ar_stab got=%0d exp=2", state_o); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL ar_outs got=%0d/%b/%b exp=0/1/0", state_o, pll_rst, sys_rst_n); end
      total++; if (lock_loss_cnt !== 2'd0 || fault !== 1'b0 || locked_stable !== 1'b0) begin bad++; $display("[TB] FAIL ar_regs got=%0d/%b/%b exp=0/0/0", lock_loss_cnt, fault, locked_stable); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(12);
      total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL ar_sync_cleared got=%0d exp=2", state_o); end
      tick(1);
      total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL ar_run got=%0d exp=3", state_o); end
   endtask

   task automatic test_soft_with_loss();
      pll_locked = 1'b0;
      tick(2);
      soft_reset_req = 1'b1;
      tick(1);
      soft_reset_req = 1'b0;
      total++; if (state_o !== 3'd0 || sys_rst_n !== 1'b0) begin bad++; $display("[TB] FAIL swl_state got=%0d/%b exp=0/0", state_o, sys_rst_n); end
      total++; if (lock_loss_cnt !== 2'd1) begin bad++; $display("[TB] FAIL swl_cnt got=%0d exp=1", lock_loss_cnt); end
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_startup();
      test_lock_loss();
      test_stabilize_glitch();
      test_timeout();
      test_soft_vs_timeout();
      test_saturation();
      test_async_reset();
      test_soft_with_loss();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
